// File: rtl/tcb_sub_mem.sv
// TCB subordinate: byte-enabled word memory with programmable wait states and a fixed response delay.
// Optional address error checking is built when TCB_SUB_MEM_ERR_EN is defined.
module tcb_sub_mem #(
    parameter int unsigned DLY  = 1,
    parameter int unsigned ADR  = 32,
    parameter int unsigned DAT  = 32,
    parameter int unsigned SIZ  = 256,
    parameter int unsigned WAIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tcb_vld,
    output logic             tcb_rdy,
    input  logic             tcb_wen,
    input  logic [ADR-1:0]   tcb_adr,
    input  logic [DAT/8-1:0] tcb_ben,
    input  logic [DAT-1:0]   tcb_wdt,
    output logic [DAT-1:0]   tcb_rdt,
    output logic             tcb_sts
);

    localparam int unsigned BEN = DAT / 8;
    localparam int unsigned ALN = $clog2(BEN);
    localparam int unsigned AW  = $clog2(SIZ);
    localparam int unsigned WRD = SIZ / BEN;
    localparam int unsigned IW  = AW - ALN;
    localparam int unsigned CW  = (WAIT > 0) ? $clog2(WAIT + 1) : 1;

    logic [CW-1:0]  cnt;
    logic           trn_c;
    logic           err_c;
    logic           wr_c;
    logic [IW-1:0]  idx_c;
    logic [DAT-1:0] rsp_c;
    logic [DAT-1:0] mem  [WRD];
    logic [DAT-1:0] prdt [DLY];
    logic           psts [DLY];

    assign tcb_rdy = rst & (cnt == CW'(WAIT));
    assign trn_c   = tcb_vld & tcb_rdy;
    assign idx_c   = tcb_adr[AW-1:ALN];

`ifdef TCB_SUB_MEM_ERR_EN
    localparam int unsigned ALW = (ALN > 0) ? ALN : 1;
    localparam logic [ALW-1:0] ALN_MSK = ALW'((1 << ALN) - 1);

    // Out of range or misaligned transfers are flagged and have no side effects.
    assign err_c = (|(tcb_adr >> AW)) | (|(tcb_adr[ALW-1:0] & ALN_MSK));
`else
    assign err_c = 1'b0;
    logic unused_adr;
    assign unused_adr = ^tcb_adr;
`endif

    assign wr_c  = trn_c & tcb_wen & ~err_c;
    assign rsp_c = (tcb_wen | err_c) ? '0 : mem[idx_c];

    // Wait-state counter: restarts on every transfer and whenever vld drops.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (trn_c || !tcb_vld) begin
            cnt <= '0;
        end else if (cnt != CW'(WAIT)) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Memory array is intentionally not reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (wr_c) begin
            for (int b = 0; b < int'(BEN); b++) begin
                if (tcb_ben[b]) begin
                    mem[idx_c][8*b +: 8] <= tcb_wdt[8*b +: 8];
                end
            end
        end
    end

    // Response pipeline: stage 0 captures each transfer, later stages shift freely.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(DLY); i++) begin
                prdt[i] <= '0;
                psts[i] <= 1'b0;
            end
        end else begin
            prdt[0] <= trn_c ? rsp_c : '0;
            psts[0] <= trn_c & err_c;
            for (int i = 1; i < int'(DLY); i++) begin
                prdt[i] <= prdt[i-1];
                psts[i] <= psts[i-1];
            end
        end
    end

    assign tcb_rdt = prdt[DLY-1];
    assign tcb_sts = psts[DLY-1];

endmodule

// File: tb/tb_tcb_sub_mem.sv
// Bench for tcb_sub_mem: three instances (DLY/WAIT = 1/0, 3/0, 2/2) checked against a response scoreboard.
module tb_tcb_sub_mem;

    logic        clk = 1'b0;
    logic [2:0]  rst;
    logic [2:0]  vld;
    logic [2:0]  rdy;
    logic [2:0]  wen;
    logic [2:0]  sts;
    logic [31:0] adr [3];
    logic [3:0]  ben [3];
    logic [31:0] wdt [3];
    logic [31:0] rdt [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] rdt;
        logic        sts;
        int          due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tcb_sub_mem #(.DLY(1), .ADR(32), .DAT(32), .SIZ(256), .WAIT(0)) u_dut0 (
        .clk(clk), .rst(rst[0]), .tcb_vld(vld[0]), .tcb_rdy(rdy[0]), .tcb_wen(wen[0]),
        .tcb_adr(adr[0]), .tcb_ben(ben[0]), .tcb_wdt(wdt[0]), .tcb_rdt(rdt[0]), .tcb_sts(sts[0]));

    tcb_sub_mem #(.DLY(3), .ADR(32), .DAT(32), .SIZ(256), .WAIT(0)) u_dut1 (
        .clk(clk), .rst(rst[1]), .tcb_vld(vld[1]), .tcb_rdy(rdy[1]), .tcb_wen(wen[1]),
        .tcb_adr(adr[1]), .tcb_ben(ben[1]), .tcb_wdt(wdt[1]), .tcb_rdt(rdt[1]), .tcb_sts(sts[1]));

    tcb_sub_mem #(.DLY(2), .ADR(32), .DAT(32), .SIZ(256), .WAIT(2)) u_dut2 (
        .clk(clk), .rst(rst[2]), .tcb_vld(vld[2]), .tcb_rdy(rdy[2]), .tcb_wen(wen[2]),
        .tcb_adr(adr[2]), .tcb_ben(ben[2]), .tcb_wdt(wdt[2]), .tcb_rdt(rdt[2]), .tcb_sts(sts[2]));

    function automatic int dly_of(input int d);
        case (d)
            0:       return 1;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int wait_of(input int d);
        return (d == 2) ? 2 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input int d, input logic [31:0] r, input logic s, input int due);
        exp_t e;
        e.rdt = r;
        e.sts = s;
        e.due = due;
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Every cycle each output must carry either the due response or zero.
    task automatic check_dut(input int d);
        exp_t        e;
        logic [31:0] er;
        logic        es;
        er = '0;
        es = 1'b0;
        case (d)
            0: if (q0.size() != 0 && q0[0].due == cyc) begin e = q0.pop_front(); er = e.rdt; es = e.sts; end
            1: if (q1.size() != 0 && q1[0].due == cyc) begin e = q1.pop_front(); er = e.rdt; es = e.sts; end
            default: if (q2.size() != 0 && q2[0].due == cyc) begin e = q2.pop_front(); er = e.rdt; es = e.sts; end
        endcase
        checks++;
        assert (rdt[d] === er && sts[d] === es) else begin
            errors++;
            $error("FAIL rsp%0d cyc=%0d observed rdt=%h sts=%b expected rdt=%h sts=%b",
                   d, cyc, rdt[d], sts[d], er, es);
        end
        if (wait_of(d) == 0) begin
            checks++;
            assert (rdy[d] === rst[d]) else begin
                errors++;
                $error("FAIL rdy%0d cyc=%0d observed=%b expected=%b", d, cyc, rdy[d], rst[d]);
            end
        end
    endtask

    always @(negedge clk) begin
        check_dut(0);
        check_dut(1);
        check_dut(2);
    end

    // Issue one request, wait for its transfer, and queue the expected response.
    task automatic req(input int d, input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] wd, input logic [31:0] er, input logic es);
        int   n;
        logic got;
        vld[d] = 1'b1;
        wen[d] = w;
        adr[d] = a;
        ben[d] = b;
        wdt[d] = wd;
        got = 1'b0;
        n = 0;
        while (!got && n < 16) begin
            @(negedge clk);
            if (rdy[d] === 1'b1) begin
                got = 1'b1;
                push(d, er, es, cyc + dly_of(d));
            end else begin
                n++;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        assert (got === 1'b1 && n == wait_of(d)) else begin
            errors++;
            $error("FAIL wait%0d adr=%h observed waited=%0d got=%b expected waited=%0d",
                   d, a, n, got, wait_of(d));
        end
    endtask

    task automatic idle(input int d, input int n);
        vld[d] = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 3'b000;
        vld = 3'b000;
        wen = 3'b000;
        for (int d = 0; d < 3; d++) begin
            adr[d] = '0;
            ben[d] = '0;
            wdt[d] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rdy0", 32'(rdy[0]), 32'h0);
        chk("reset_rdy2", 32'(rdy[2]), 32'h0);
        chk("reset_rdt1", rdt[1], 32'h0);
        @(posedge clk);
        #1;
        rst = 3'b111;

        // DLY=1, WAIT=0: basic write/read, byte enables, read-after-write.
        req(0, 1'b1, 32'h00, 4'hF, 32'h01234567, 32'h0, 1'b0);
        req(0, 1'b0, 32'h00, 4'hF, 32'h0, 32'h01234567, 1'b0);
        req(0, 1'b1, 32'h00, 4'b0101, 32'hAABBCCDD, 32'h0, 1'b0);
        req(0, 1'b0, 32'h00, 4'h0, 32'h0, 32'h01BB45DD, 1'b0);
        req(0, 1'b1, 32'h08, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0);
        req(0, 1'b0, 32'h08, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0);
        req(0, 1'b1, 32'h04, 4'hF, 32'h0BADC0DE, 32'h0, 1'b0);
        req(0, 1'b1, 32'h10, 4'hF, 32'h10101010, 32'h0, 1'b0);
`ifdef TCB_SUB_MEM_ERR_EN
        req(0, 1'b0, 32'h11, 4'hF, 32'h0, 32'h0, 1'b1);
        req(0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0, 1'b1);
        req(0, 1'b0, 32'h00, 4'hF, 32'h0, 32'h01BB45DD, 1'b0);
        req(0, 1'b1, 32'h104, 4'hF, 32'h5A5A1234, 32'h0, 1'b1);
        req(0, 1'b0, 32'h04, 4'hF, 32'h0, 32'h0BADC0DE, 1'b0);
`else
        req(0, 1'b0, 32'h11, 4'hF, 32'h0, 32'h10101010, 1'b0);
        req(0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0);
        req(0, 1'b0, 32'h00, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0);
        req(0, 1'b1, 32'h104, 4'hF, 32'h5A5A1234, 32'h0, 1'b0);
        req(0, 1'b0, 32'h04, 4'hF, 32'h0, 32'h5A5A1234, 1'b0);
`endif
        idle(0, 3);

        // DLY=3, WAIT=0: three responses in flight, zero after the last.
        req(1, 1'b1, 32'h00, 4'hF, 32'h11, 32'h0, 1'b0);
        req(1, 1'b1, 32'h04, 4'hF, 32'h22, 32'h0, 1'b0);
        req(1, 1'b1, 32'h08, 4'hF, 32'h33, 32'h0, 1'b0);
        idle(1, 1);
        req(1, 1'b0, 32'h00, 4'hF, 32'h0, 32'h11, 1'b0);
        req(1, 1'b0, 32'h04, 4'hF, 32'h0, 32'h22, 1'b0);
        req(1, 1'b0, 32'h08, 4'hF, 32'h0, 32'h33, 1'b0);
        idle(1, 5);

        // DLY=2, WAIT=2: preload, then exact rdy pattern for two back-to-back reads.
        req(2, 1'b1, 32'h00, 4'hF, 32'h11, 32'h0, 1'b0);
        req(2, 1'b1, 32'h04, 4'hF, 32'h22, 32'h0, 1'b0);
        req(2, 1'b1, 32'h20, 4'hF, 32'h5EED5EED, 32'h0, 1'b0);
        idle(2, 3);
        vld[2] = 1'b1;
        wen[2] = 1'b0;
        adr[2] = 32'h00;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("rdy_pattern_c%0d", i), 32'(rdy[2]), (i == 2 || i == 5) ? 32'h1 : 32'h0);
            if (i == 2) push(2, 32'h11, 1'b0, cyc + 2);
            if (i == 5) push(2, 32'h22, 1'b0, cyc + 2);
            @(posedge clk);
            #1;
            if (i == 2) adr[2] = 32'h04;
        end
        idle(2, 3);

        // Reset right after a read transfer: the in-flight response is dropped.
        req(2, 1'b0, 32'h20, 4'hF, 32'h0, 32'h5EED5EED, 1'b0);
        rst[2] = 1'b0;
        vld[2] = 1'b0;
        q2.delete();
        repeat (3) begin
            @(negedge clk);
            chk("rst_rdy2", 32'(rdy[2]), 32'h0);
            chk("rst_rdt2", rdt[2], 32'h0);
            @(posedge clk);
            #1;
        end
        rst[2] = 1'b1;
        idle(2, 4);
        req(2, 1'b0, 32'h20, 4'hF, 32'h0, 32'h5EED5EED, 1'b0);
        idle(2, 4);

        chk("drain_q0", 32'(q0.size()), 32'h0);
        chk("drain_q1", 32'(q1.size()), 32'h0);
        chk("drain_q2", 32'(q2.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tcb_sub_mem.md
Name: tcb_sub_mem

Overview:
- Synthesizable TCB subordinate: a byte-enabled word memory that answers manager transfers with programmable wait states and a fixed response delay.
- Acts as the responder end of the TCB link, the RTL counterpart to the VIP manager; used as on-chip RAM behind interconnect and as the DUT for manager-side benches.
- Response data and status follow each transfer after exactly DLY cycles; there is no response backpressure.

Parameters:
- DLY, 1: response delay in cycles after a transfer; legal range is 1 or more.
- ADR, 32: address width.
- DAT, 32: data width; must be a multiple of 8. BEN = DAT/8. ALN = clog2(BEN).
- SIZ, 256: memory size in bytes; a power of two and a multiple of BEN. Word count is SIZ/BEN.
- WAIT, 0: number of wait-state cycles inserted before rdy per request.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- tcb_vld  in  1  request valid.
- tcb_rdy  out  1  request ready.
- tcb_wen  in  1  write enable; 1 = write, 0 = read.
- tcb_adr  in  ADR  byte address.
- tcb_ben  in  BEN  byte enables.
- tcb_wdt  in  DAT  write data.
- tcb_rdt  out  DAT  read data; valid DLY cycles after the transfer.
- tcb_sts  out  1  error status; valid DLY cycles after the transfer.

Behaviour:
- Transfer (trn) = tcb_vld & tcb_rdy at a rising edge.
- Reset (rst = 0 at an edge):
  - Wait counter cleared to 0; tcb_rdy forced to 0 while rst = 0.
  - All response pipeline stages cleared, so tcb_rdt = 0 and tcb_sts = 0.
  - Responses still in flight are discarded.
  - Memory array is not reset; contents are retained.
- Wait-state counter cnt, range 0..WAIT:
  - tcb_rdy = rst & (cnt == WAIT). When WAIT = 0, tcb_rdy = 1 whenever the block is out of reset.
  - vld & !rdy: cnt increments by 1.
  - On trn: cnt returns to 0, so every request, including back-to-back ones, waits WAIT cycles.
  - vld dropping before trn (a protocol violation): cnt returns to 0 without error.
- Write, on trn with wen = 1:
  - Word index is adr[clog2(SIZ)-1:ALN].
  - Only bytes with ben = 1 are updated, at the trn edge.
  - tcb_rdt for a write response is 0.
- Read, on trn with wen = 0:
  - The full word is read at the trn edge; ben is ignored for reads.
  - A write in cycle N followed by a read of the same address in cycle N+1 returns the new data.
- Response pipeline:
  - Stage 0 is loaded at every edge: {rdt, sts} when trn, else {0, 0}.
  - Stages 1..DLY-1 shift unconditionally.
  - tcb_rdt/tcb_sts are driven from the last stage, so the response for a trn in cycle N appears in cycle N+DLY.
  - Responses come out in order; up to DLY responses can be in flight.
- Without TCB_SUB_MEM_ERR_EN:
  - Address is taken modulo SIZ.
  - adr[ALN-1:0] is ignored.
  - tcb_sts is tied to 0.

Optional Feature:
- Macro: TCB_SUB_MEM_ERR_EN.
- When defined, error = (adr >= SIZ) | (adr[ALN-1:0] != 0), evaluated at trn. On error:
  - An erroneous write is suppressed; memory is unchanged.
  - An erroneous read returns rdt = 0.
  - tcb_sts = 1 in the response slot of that transfer.
- When not defined:
  - No error logic is built; tcb_sts is constant 0.
  - Out-of-range addresses alias into the array.

Test Plan:
1. DLY=1, WAIT=0: write adr 0x00 data 0x01234567 ben 0xF, then read 0x00. Required: rdt = 0x01234567 and sts = 0 in the cycle after the read trn; rdy stays 1 throughout.
2. Write 0xAABBCCDD to 0x00 with ben 4'b0101 over 0x01234567, then read 0x00. Required: rdt = 0x01BB45DD.
3. WAIT=2: vld held high for two back-to-back reads starting at cycle 0. Required: rdy = 1 only in cycles 2 and 5; trn occurs in cycles 2 and 5.
4. DLY=3: preload 0x00/0x04/0x08 with 0x11, 0x22, 0x33; issue back-to-back reads in cycles N..N+2. Required: rdt = 0x11, 0x22, 0x33 in cycles N+3..N+5, and rdt = 0 in cycle N+6.
5. Reset mid-operation: read trn in cycle N, rst = 0 in cycle N+1, DLY=2. Required: rdt = 0 and rdy = 0 while in reset, and no stale response appears. A read after reset returns the pre-reset memory contents.
6. Address errors:
   - With TCB_SUB_MEM_ERR_EN: read 0x11 gives sts = 1, rdt = 0; write 0x100 gives sts = 1 and memory unchanged.
   - Without the macro: a write to 0x104 followed by a read of 0x04 returns the written data with sts = 0.
